// File: rtl/trap_csr_if.sv
`default_nettype none
// ============================================================================
// Module   : trap_csr_if
// Brief    : Trap/CSR request and response bundle between core and trap_csr.
// Revision : 1.0
// ============================================================================
interface trap_csr_if #(
    parameter int CSR_ADDR_W = 12
);
    logic                  MMU_WAIT;
    logic                  TRAP_EN;
    logic [31:0]           TRAP_PC;
    logic [31:0]           TRAP_CODE;
    logic [31:0]           TRAP_JMP_TO;
    logic                  MRET_EN;
    logic                  CSR_WREN;
    logic [CSR_ADDR_W-1:0] CSR_ADDR;
    logic [31:0]           CSR_WDATA;
    logic [31:0]           CSR_RDATA;
    logic [1:0]            TRAP_VEC_MODE;
    logic [31:0]           TRAP_VEC_BASE;
    logic                  INT_ALLOW;
    logic [1:0]            MODE;
    logic                  JMP_EN;
    logic [31:0]           JMP_TO;
    logic                  BUSY;

    modport master (
        output MMU_WAIT, TRAP_EN, TRAP_PC, TRAP_CODE, TRAP_JMP_TO, MRET_EN,
               CSR_WREN, CSR_ADDR, CSR_WDATA,
        input  CSR_RDATA, TRAP_VEC_MODE, TRAP_VEC_BASE, INT_ALLOW, MODE,
               JMP_EN, JMP_TO, BUSY
    );

    modport slave (
        input  MMU_WAIT, TRAP_EN, TRAP_PC, TRAP_CODE, TRAP_JMP_TO, MRET_EN,
               CSR_WREN, CSR_ADDR, CSR_WDATA,
        output CSR_RDATA, TRAP_VEC_MODE, TRAP_VEC_BASE, INT_ALLOW, MODE,
               JMP_EN, JMP_TO, BUSY
    );
endinterface
`default_nettype wire

// File: rtl/trap_csr.sv
`default_nettype none
// ============================================================================
// Module   : trap_csr
// Brief    : Machine-mode trap CSRs with trap entry / MRET redirect sequencing.
// Revision : 1.0
// ============================================================================
module trap_csr #(
    parameter logic [1:0] RESET_MODE = 2'b11,
    parameter int         CSR_ADDR_W = 12
) (
    input  wire logic  CLK,
    input  wire logic  RST,
    trap_csr_if.slave  bus
);
    localparam logic [CSR_ADDR_W-1:0] c_ADDR_MSTATUS  = CSR_ADDR_W'(12'h300);
    localparam logic [CSR_ADDR_W-1:0] c_ADDR_MTVEC    = CSR_ADDR_W'(12'h305);
    localparam logic [CSR_ADDR_W-1:0] c_ADDR_MSCRATCH = CSR_ADDR_W'(12'h340);
    localparam logic [CSR_ADDR_W-1:0] c_ADDR_MEPC     = CSR_ADDR_W'(12'h341);
    localparam logic [CSR_ADDR_W-1:0] c_ADDR_MCAUSE   = CSR_ADDR_W'(12'h342);

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_REDIRECT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;
    logic [1:0]  mpp_q, mpp_d;
    logic [1:0]  mode_q, mode_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] tgt_q, tgt_d;

    logic w_trap_go;
    logic w_mret_go;
    logic w_wr_mstatus, w_wr_mtvec, w_wr_mscratch, w_wr_mepc, w_wr_mcause;

    always_comb begin
        w_trap_go     = (state_q == S_IDLE) && bus.TRAP_EN;
        w_mret_go     = (state_q == S_IDLE) && bus.MRET_EN && !bus.TRAP_EN;
        w_wr_mstatus  = bus.CSR_WREN && (bus.CSR_ADDR == c_ADDR_MSTATUS);
        w_wr_mtvec    = bus.CSR_WREN && (bus.CSR_ADDR == c_ADDR_MTVEC);
        w_wr_mscratch = bus.CSR_WREN && (bus.CSR_ADDR == c_ADDR_MSCRATCH);
        w_wr_mepc     = bus.CSR_WREN && (bus.CSR_ADDR == c_ADDR_MEPC);
        w_wr_mcause   = bus.CSR_WREN && (bus.CSR_ADDR == c_ADDR_MCAUSE);

        state_d    = (state_q == S_REDIRECT) ? S_IDLE : state_q;
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mpp_d      = mpp_q;
        mode_d     = mode_q;
        mtvec_d    = w_wr_mtvec    ? bus.CSR_WDATA : mtvec_q;
        mscratch_d = w_wr_mscratch ? bus.CSR_WDATA : mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        tgt_d      = tgt_q;

        // Entry owns mstatus/mepc/mcause this cycle; a colliding CSR write to them is dropped.
        if (w_trap_go) begin
            mepc_d   = {bus.TRAP_PC[31:2], 2'b00};
            mcause_d = bus.TRAP_CODE;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
            mpp_d    = mode_q;
            mode_d   = 2'b11;
            tgt_d    = bus.TRAP_JMP_TO;
            state_d  = S_REDIRECT;
        end else if (w_mret_go) begin
            mie_d    = mpie_q;
            mpie_d   = 1'b1;
            mode_d   = mpp_q;
            mpp_d    = 2'b00;
            tgt_d    = mepc_q;
            state_d  = S_REDIRECT;
        end else begin
            if (w_wr_mstatus) begin
                mie_d  = bus.CSR_WDATA[3];
                mpie_d = bus.CSR_WDATA[7];
                mpp_d  = bus.CSR_WDATA[12:11];
            end
            if (w_wr_mepc) begin
                mepc_d = {bus.CSR_WDATA[31:2], 2'b00};
            end
            if (w_wr_mcause) begin
                mcause_d = bus.CSR_WDATA;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mpp_q      <= 2'b00;
            mode_q     <= RESET_MODE;
            mtvec_q    <= 32'h0;
            mscratch_q <= 32'h0;
            mepc_q     <= 32'h0;
            mcause_q   <= 32'h0;
            tgt_q      <= 32'h0;
        end else if (!bus.MMU_WAIT) begin
            state_q    <= state_d;
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mpp_q      <= mpp_d;
            mode_q     <= mode_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            tgt_q      <= tgt_d;
        end
    end

    always_comb begin
        bus.CSR_RDATA = 32'h0;
        case (bus.CSR_ADDR)
            c_ADDR_MSTATUS:  bus.CSR_RDATA = {19'h0, mpp_q, 3'b000, mpie_q, 3'b000, mie_q, 3'b000};
            c_ADDR_MTVEC:    bus.CSR_RDATA = mtvec_q;
            c_ADDR_MSCRATCH: bus.CSR_RDATA = mscratch_q;
            c_ADDR_MEPC:     bus.CSR_RDATA = mepc_q;
            c_ADDR_MCAUSE:   bus.CSR_RDATA = mcause_q;
            default:         bus.CSR_RDATA = 32'h0;
        endcase
    end

    assign bus.JMP_EN        = (state_q == S_REDIRECT);
    assign bus.JMP_TO        = (state_q == S_REDIRECT) ? tgt_q : 32'h0;
    assign bus.BUSY          = (state_q != S_IDLE);
    assign bus.INT_ALLOW     = mie_q;
    assign bus.MODE          = mode_q;
    assign bus.TRAP_VEC_MODE = mtvec_q[1:0];
    assign bus.TRAP_VEC_BASE = {mtvec_q[31:2], 2'b00};

endmodule
`default_nettype wire

// File: tb/tb_trap_csr.sv
`default_nettype none
// ============================================================================
// Module   : tb_trap_csr
// Brief    : Directed and randomized checks of trap_csr against a CSR-level model.
// Revision : 1.0
// ============================================================================
module tb_trap_csr;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    trap_csr_if #(.CSR_ADDR_W(12)) bus ();

    trap_csr #(
        .RESET_MODE (2'b11),
        .CSR_ADDR_W (12)
    ) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state held as whole architectural words
    logic [31:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause, m_tgt;
    logic [1:0]  m_mode;
    bit          m_redirect;

    task automatic model_reset();
        m_mstatus = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
        m_tgt = 0; m_mode = 2'b11; m_redirect = 0;
    endtask

    function automatic logic [31:0] model_read(logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        bit          entry;
        logic [31:0] old;
        entry = 0;
        if (!rst_n || bus.MMU_WAIT) return;
        if (m_redirect) begin
            m_redirect = 0;
        end else if (bus.TRAP_EN) begin
            m_mepc     = bus.TRAP_PC & ~32'h3;
            m_mcause   = bus.TRAP_CODE;
            m_mstatus  = (m_mstatus[3] ? 32'h80 : 32'h0) | (32'(m_mode) << 11);
            m_mode     = 2'b11;
            m_tgt      = bus.TRAP_JMP_TO;
            m_redirect = 1; entry = 1;
        end else if (bus.MRET_EN) begin
            old        = m_mstatus;
            m_mode     = old[12:11];
            m_mstatus  = (old[7] ? 32'h8 : 32'h0) | 32'h80;
            m_tgt      = m_mepc;
            m_redirect = 1; entry = 1;
        end
        if (bus.CSR_WREN) begin
            case (bus.CSR_ADDR)
                12'h300: if (!entry) m_mstatus = bus.CSR_WDATA & 32'h0000_1888;
                12'h305: m_mtvec = bus.CSR_WDATA;
                12'h340: m_mscratch = bus.CSR_WDATA;
                12'h341: if (!entry) m_mepc = bus.CSR_WDATA & ~32'h3;
                12'h342: if (!entry) m_mcause = bus.CSR_WDATA;
                default: ;
            endcase
        end
    endtask

    task automatic idle_inputs();
        bus.MMU_WAIT = 0; bus.TRAP_EN = 0; bus.MRET_EN = 0; bus.CSR_WREN = 0;
        bus.TRAP_PC = 0; bus.TRAP_CODE = 0; bus.TRAP_JMP_TO = 0;
        bus.CSR_ADDR = 0; bus.CSR_WDATA = 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(logic [11:0] a, logic [31:0] d);
        bus.CSR_WREN = 1; bus.CSR_ADDR = a; bus.CSR_WDATA = d;
        tick();
        bus.CSR_WREN = 0;
    endtask

    task automatic set_read(logic [11:0] a);
        bus.CSR_WREN = 0; bus.CSR_ADDR = a;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.JMP_EN !== 1'b0 || bus.BUSY !== 1'b0 || bus.JMP_TO !== 32'h0)
            $display("FAIL reset_jmp: jmp_en=%0b busy=%0b jmp_to=%h want 0/0/0", bus.JMP_EN, bus.BUSY, bus.JMP_TO); else n_pass++;
        n_checks++; if (bus.MODE !== 2'b11) $display("FAIL reset_mode: got %0d want 3", bus.MODE); else n_pass++;
        n_checks++; if (bus.INT_ALLOW !== 1'b0 || bus.TRAP_VEC_MODE !== 2'b0 || bus.TRAP_VEC_BASE !== 32'h0)
            $display("FAIL reset_vec: ie=%0b vmode=%0d vbase=%h want 0/0/0", bus.INT_ALLOW, bus.TRAP_VEC_MODE, bus.TRAP_VEC_BASE); else n_pass++;
        set_read(12'h342);
        n_checks++; if (bus.CSR_RDATA !== 32'h0) $display("FAIL reset_mcause: got %h want 0", bus.CSR_RDATA); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic test_trap_entry();
        csr_write(12'h300, 32'h8);
        n_checks++; if (bus.INT_ALLOW !== 1'b1) $display("FAIL mie_write: got %0b want 1", bus.INT_ALLOW); else n_pass++;
        bus.TRAP_EN = 1; bus.TRAP_PC = 32'h100; bus.TRAP_CODE = 32'h2; bus.TRAP_JMP_TO = 32'h8000_0000;
        tick();
        bus.TRAP_EN = 0;
        n_checks++; if (bus.JMP_EN !== 1'b1 || bus.JMP_TO !== 32'h8000_0000 || bus.BUSY !== 1'b1)
            $display("FAIL trap_redirect: en=%0b to=%h busy=%0b want 1/80000000/1", bus.JMP_EN, bus.JMP_TO, bus.BUSY); else n_pass++;
        set_read(12'h341);
        n_checks++; if (bus.CSR_RDATA !== 32'h100) $display("FAIL trap_mepc: got %h want 100", bus.CSR_RDATA); else n_pass++;
        set_read(12'h342);
        n_checks++; if (bus.CSR_RDATA !== 32'h2) $display("FAIL trap_mcause: got %h want 2", bus.CSR_RDATA); else n_pass++;
        set_read(12'h300);
        n_checks++; if (bus.CSR_RDATA !== 32'h1880) $display("FAIL trap_mstatus: got %h want 1880", bus.CSR_RDATA); else n_pass++;
        n_checks++; if (bus.INT_ALLOW !== 1'b0 || bus.MODE !== 2'b11)
            $display("FAIL trap_ie_mode: ie=%0b mode=%0d want 0/3", bus.INT_ALLOW, bus.MODE); else n_pass++;
        tick();
        n_checks++; if (bus.JMP_EN !== 1'b0 || bus.JMP_TO !== 32'h0 || bus.BUSY !== 1'b0)
            $display("FAIL trap_oneshot: en=%0b to=%h busy=%0b want 0/0/0", bus.JMP_EN, bus.JMP_TO, bus.BUSY); else n_pass++;
    endtask

    task automatic test_mret();
        bus.MRET_EN = 1;
        tick();
        bus.MRET_EN = 0;
        n_checks++; if (bus.JMP_EN !== 1'b1 || bus.JMP_TO !== 32'h100)
            $display("FAIL mret_redirect: en=%0b to=%h want 1/100", bus.JMP_EN, bus.JMP_TO); else n_pass++;
        set_read(12'h300);
        n_checks++; if (bus.CSR_RDATA !== 32'h88) $display("FAIL mret_mstatus: got %h want 88", bus.CSR_RDATA); else n_pass++;
        n_checks++; if (bus.MODE !== 2'b11 || bus.INT_ALLOW !== 1'b1)
            $display("FAIL mret_mode_ie: mode=%0d ie=%0b want 3/1", bus.MODE, bus.INT_ALLOW); else n_pass++;
        tick();
    endtask

    task automatic test_simultaneous();
        bus.TRAP_EN = 1; bus.MRET_EN = 1;
        bus.TRAP_PC = 32'h207; bus.TRAP_CODE = 32'h8000_0007; bus.TRAP_JMP_TO = 32'h1234_5678;
        bus.CSR_WREN = 1; bus.CSR_ADDR = 12'h340; bus.CSR_WDATA = 32'hDEAD_BEEF;
        tick();
        bus.TRAP_EN = 0; bus.MRET_EN = 0; bus.CSR_WREN = 0;
        n_checks++; if (bus.JMP_EN !== 1'b1 || bus.JMP_TO !== 32'h1234_5678)
            $display("FAIL simul_redirect: en=%0b to=%h want 1/12345678", bus.JMP_EN, bus.JMP_TO); else n_pass++;
        set_read(12'h341);
        n_checks++; if (bus.CSR_RDATA !== 32'h204) $display("FAIL simul_mepc: got %h want 204", bus.CSR_RDATA); else n_pass++;
        set_read(12'h340);
        n_checks++; if (bus.CSR_RDATA !== 32'hDEAD_BEEF) $display("FAIL simul_mscratch: got %h want deadbeef", bus.CSR_RDATA); else n_pass++;
        // A write to mepc while in REDIRECT lands normally
        csr_write(12'h341, 32'h0000_0333);
        set_read(12'h341);
        n_checks++; if (bus.CSR_RDATA !== 32'h330) $display("FAIL redirect_wr_mepc: got %h want 330", bus.CSR_RDATA); else n_pass++;
    endtask

    task automatic test_stall();
        bus.TRAP_EN = 1; bus.TRAP_PC = 32'h400; bus.TRAP_CODE = 32'h5; bus.TRAP_JMP_TO = 32'hA5A5_0000;
        tick();
        bus.TRAP_JMP_TO = 32'h0BAD_0000;
        bus.MMU_WAIT = 1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.JMP_EN !== 1'b1 || bus.JMP_TO !== 32'hA5A5_0000)
                $display("FAIL stall_hold%0d: en=%0b to=%h want 1/a5a50000", i, bus.JMP_EN, bus.JMP_TO); else n_pass++;
            tick();
        end
        bus.MMU_WAIT = 0;
        n_checks++; if (bus.JMP_EN !== 1'b1 || bus.JMP_TO !== 32'hA5A5_0000)
            $display("FAIL stall_last: en=%0b to=%h want 1/a5a50000", bus.JMP_EN, bus.JMP_TO); else n_pass++;
        tick();
        bus.TRAP_EN = 0;
        n_checks++; if (bus.JMP_EN !== 1'b0 || bus.JMP_TO !== 32'h0)
            $display("FAIL stall_release: en=%0b to=%h want 0/0", bus.JMP_EN, bus.JMP_TO); else n_pass++;
    endtask

    task automatic test_mtvec();
        csr_write(12'h305, 32'h2000_0101);
        n_checks++; if (bus.TRAP_VEC_MODE !== 2'd1 || bus.TRAP_VEC_BASE !== 32'h2000_0100)
            $display("FAIL mtvec_out: vmode=%0d vbase=%h want 1/20000100", bus.TRAP_VEC_MODE, bus.TRAP_VEC_BASE); else n_pass++;
        set_read(12'h305);
        n_checks++; if (bus.CSR_RDATA !== 32'h2000_0101) $display("FAIL mtvec_read: got %h want 20000101", bus.CSR_RDATA); else n_pass++;
        csr_write(12'h7C0, 32'hFFFF_FFFF);
        set_read(12'h7C0);
        n_checks++; if (bus.CSR_RDATA !== 32'h0) $display("FAIL unmapped_read: got %h want 0", bus.CSR_RDATA); else n_pass++;
    endtask

    task automatic test_random();
        logic [11:0] addrs [6];
        logic [11:0] ra;
        int          k;
        addrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h7C0};
        for (int i = 0; i < 400; i++) begin
            bus.MMU_WAIT    = ($urandom_range(0, 4) == 0);
            bus.TRAP_EN     = ($urandom_range(0, 5) == 0);
            bus.MRET_EN     = ($urandom_range(0, 4) == 0);
            bus.TRAP_PC     = $urandom;
            bus.TRAP_CODE   = $urandom;
            bus.TRAP_JMP_TO = $urandom;
            bus.CSR_WREN    = $urandom_range(0, 1) == 1;
            k = $urandom_range(0, 6);
            bus.CSR_ADDR    = (k == 6) ? 12'($urandom) : addrs[k];
            bus.CSR_WDATA   = $urandom;
            #1;
            ra = bus.CSR_ADDR;
            n_checks++; if (bus.CSR_RDATA !== model_read(ra))
                $display("FAIL rnd_rdata[%0d] @%h: got %h want %h", i, ra, bus.CSR_RDATA, model_read(ra)); else n_pass++;
            n_checks++; if (bus.JMP_EN !== m_redirect || bus.BUSY !== m_redirect || bus.JMP_TO !== (m_redirect ? m_tgt : 32'h0))
                $display("FAIL rnd_jmp[%0d]: en=%0b busy=%0b to=%h want %0b/%0b/%h", i, bus.JMP_EN, bus.BUSY, bus.JMP_TO,
                         m_redirect, m_redirect, m_redirect ? m_tgt : 32'h0); else n_pass++;
            n_checks++; if (bus.MODE !== m_mode || bus.INT_ALLOW !== m_mstatus[3] ||
                            bus.TRAP_VEC_MODE !== m_mtvec[1:0] || bus.TRAP_VEC_BASE !== (m_mtvec & ~32'h3))
                $display("FAIL rnd_status[%0d]: mode=%0d ie=%0b vm=%0d vb=%h want %0d/%0b/%0d/%h", i, bus.MODE, bus.INT_ALLOW,
                         bus.TRAP_VEC_MODE, bus.TRAP_VEC_BASE, m_mode, m_mstatus[3], m_mtvec[1:0], m_mtvec & ~32'h3); else n_pass++;
            tick();
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_reset_mid_redirect();
        bus.TRAP_EN = 1; bus.TRAP_PC = 32'h7FC; bus.TRAP_CODE = 32'h3; bus.TRAP_JMP_TO = 32'h4000_0000;
        tick();
        bus.TRAP_EN = 0;
        n_checks++; if (bus.JMP_EN !== 1'b1) $display("FAIL rst_mid_pre: en=%0b want 1", bus.JMP_EN); else n_pass++;
        rst_n = 0;
        model_reset();
        #1;
        n_checks++; if (bus.JMP_EN !== 1'b0 || bus.JMP_TO !== 32'h0 || bus.BUSY !== 1'b0)
            $display("FAIL rst_mid_jmp: en=%0b to=%h busy=%0b want 0/0/0", bus.JMP_EN, bus.JMP_TO, bus.BUSY); else n_pass++;
        set_read(12'h341);
        n_checks++; if (bus.CSR_RDATA !== 32'h0) $display("FAIL rst_mid_mepc: got %h want 0", bus.CSR_RDATA); else n_pass++;
        n_checks++; if (bus.MODE !== 2'b11 || bus.INT_ALLOW !== 1'b0 || bus.TRAP_VEC_BASE !== 32'h0)
            $display("FAIL rst_mid_state: mode=%0d ie=%0b vb=%h want 3/0/0", bus.MODE, bus.INT_ALLOW, bus.TRAP_VEC_BASE); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1;
        csr_write(12'h340, 32'h1357_9BDF);
        set_read(12'h340);
        n_checks++; if (bus.CSR_RDATA !== 32'h1357_9BDF) $display("FAIL post_rst_write: got %h want 13579bdf", bus.CSR_RDATA); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_trap_entry();
        test_mret();
        test_simultaneous();
        test_stall();
        test_mtvec();
        test_random();
        test_reset_mid_redirect();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/trap_csr.md
TRAP_CSR -- requirements
Module: trap_csr

Interface
REQ-001 SHALL have parameter RESET_MODE, default 2'b11, meaning the privilege mode loaded at reset.
REQ-002 SHALL have parameter CSR_ADDR_W, default 12, meaning the CSR address width.
REQ-003 SHALL have port CLK, in, 1, the single clock.
REQ-004 SHALL have port RST, in, 1, asynchronous active-low reset.
REQ-005 SHALL have port MMU_WAIT, in, 1, stall; when high, all state is held.
REQ-006 SHALL have port TRAP_EN, in, 1, trap request.
REQ-007 SHALL have port TRAP_PC, in, 32, faulting PC.
REQ-008 SHALL have port TRAP_CODE, in, 32, cause; bit31 = interrupt.
REQ-009 SHALL have port TRAP_JMP_TO, in, 32, handler address.
REQ-010 SHALL have port MRET_EN, in, 1, trap-return request.
REQ-011 SHALL have port CSR_WREN, in, 1, CSR write strobe.
REQ-012 SHALL have port CSR_ADDR, in, CSR_ADDR_W, CSR address.
REQ-013 SHALL have port CSR_WDATA, in, 32, CSR write data.
REQ-014 SHALL have port CSR_RDATA, out, 32, combinational CSR read data.
REQ-015 SHALL have port TRAP_VEC_MODE, out, 2, mtvec[1:0].
REQ-016 SHALL have port TRAP_VEC_BASE, out, 32, {mtvec[31:2],2'b00}.
REQ-017 SHALL have port INT_ALLOW, out, 1, mstatus.MIE.
REQ-018 SHALL have port MODE, out, 2, current privilege mode.
REQ-019 SHALL have port JMP_EN, out, 1, one-cycle redirect and flush strobe.
REQ-020 SHALL have port JMP_TO, out, 32, redirect target.
REQ-021 SHALL have port BUSY, out, 1, high while state is not IDLE.

Function
REQ-022 SHALL implement the CSR map: 0x300 mstatus (MIE b3, MPIE b7, MPP b12:11, other bits read 0), 0x305 mtvec, 0x340 mscratch, 0x341 mepc, 0x342 mcause.
REQ-023 SHALL read unmapped addresses as 0 and ignore writes to them.
REQ-024 SHALL clear mepc[1:0] on every write to mepc.
REQ-025 SHALL store mtvec writes unmodified, with TRAP_VEC_BASE masking bits [1:0].
REQ-026 SHALL use a two-state FSM, IDLE and REDIRECT, with every register updating on the CLK rising edge only when MMU_WAIT=0.
REQ-027 SHALL, in IDLE with TRAP_EN=1, perform on the next edge:
- mepc<=TRAP_PC&~3
- mcause<=TRAP_CODE
- MPIE<=MIE, MIE<=0, MPP<=MODE, MODE<=2'b11
- tgt<=TRAP_JMP_TO
- state<=REDIRECT
REQ-028 SHALL, in IDLE with MRET_EN=1 and TRAP_EN=0, perform on the next edge:
- MIE<=MPIE, MPIE<=1, MODE<=MPP, MPP<=2'b00
- tgt<=mepc
- state<=REDIRECT
REQ-029 SHALL, in REDIRECT, drive JMP_EN=1 and JMP_TO=tgt for exactly one unstalled cycle, then return to IDLE; latency is request edge +1 cycle.
REQ-030 SHALL extend REDIRECT while MMU_WAIT=1, keeping JMP_EN and JMP_TO stable.
REQ-031 SHALL give TRAP_EN priority when TRAP_EN and MRET_EN are asserted together, ignoring MRET.
REQ-032 SHALL ignore TRAP_EN and MRET_EN while in REDIRECT, with no queuing.
REQ-033 SHALL, when a CSR write coincides with trap or MRET entry, apply the trap/MRET update to mstatus/mepc/mcause and the CSR write to all other CSRs.
REQ-034 SHALL apply CSR writes in REDIRECT normally.
REQ-035 SHALL drive JMP_TO=0 whenever JMP_EN=0.
REQ-036 SHALL have CSR_RDATA reflect register contents before the current edge.

Reset
REQ-037 SHALL, with RST=0 at any time including mid-REDIRECT, immediately force:
- all CSRs to 0
- MODE=RESET_MODE
- state=IDLE
- JMP_EN=0, JMP_TO=0, BUSY=0, INT_ALLOW=0, TRAP_VEC_MODE=0, TRAP_VEC_BASE=0
REQ-038 SHALL perform the first update at the first rising edge after RST deasserts.

Verification
REQ-039 SHALL cover trap entry:
- stimulus: write mstatus=0x8, then TRAP_EN with PC=0x100, CODE=0x2, JMP_TO=0x8000_0000
- response: next cycle JMP_EN=1, JMP_TO=0x8000_0000; mepc=0x100; mcause=2; mstatus=0x1880
REQ-040 SHALL cover MRET after that trap:
- stimulus: MRET_EN
- response: JMP_EN=1, JMP_TO=0x100; mstatus=0x88; MODE=3
REQ-041 SHALL cover simultaneous TRAP_EN and MRET_EN:
- response: trap path taken; JMP_TO=TRAP_JMP_TO
REQ-042 SHALL cover a stall during REDIRECT:
- stimulus: MMU_WAIT=1 for 3 cycles during REDIRECT
- response: JMP_EN held high 4 cycles total with JMP_TO unchanged
REQ-043 SHALL cover the mtvec write:
- stimulus: write mtvec=0x2000_0101
- response: TRAP_VEC_MODE=1, TRAP_VEC_BASE=0x2000_0100; reading 0x7C0 returns 0
REQ-044 SHALL cover reset mid-REDIRECT:
- stimulus: RST=0 during REDIRECT
- response: JMP_EN=0 immediately; mepc=0; MODE=3
